// File: rtl/hl_audio_pkg.sv
// rtl/hl_audio_pkg.sv - shared state encoding and constants for the audio receive path
package hl_audio_pkg;

    localparam int DATA_W_DEFAULT = 16;
    localparam int SYNC_DEPTH     = 2;

    typedef enum logic [1:0] {
        WAIT_ALIGN = 2'd0,
        DELAY      = 2'd1,
        SHIFT      = 2'd2,
        PAD        = 2'd3
    } rx_state_e;

endpackage

// File: rtl/sync_bits.sv
// rtl/sync_bits.sv - multi-bit flop-chain synchronizer, all bits share one depth
module sync_bits #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stage <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/i2s_mic_rx.sv
// rtl/i2s_mic_rx.sv - I2S microphone receiver with pair handshake; I2S_RX_FRAME_CHECK_EN enables frame_err
module i2s_mic_rx
    import hl_audio_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int SYNC_STAGES = SYNC_DEPTH
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              bclk,
    input  logic              lrclk,
    input  logic              sdata,
    output logic [DATA_W-1:0] left_data,
    output logic [DATA_W-1:0] right_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [2:0]        sync_q;
    logic              bclk_s, lrclk_s, sdata_s;
    logic              bclk_d, lr_last, bit_event, lr_change;
    rx_state_e         state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] shreg;
    logic [DATA_W-1:0] word, left_hold;
    logic              chan, left_ok, take, store, abandon, last_bit, pair_done;

    // One chain for all three lines keeps lrclk/sdata aligned with the bclk edge.
    sync_bits #(.WIDTH(3), .DEPTH(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .din    ({bclk, lrclk, sdata}),
        .dout   (sync_q)
    );

    assign {bclk_s, lrclk_s, sdata_s} = sync_q;
    assign bit_event = bclk_s & ~bclk_d;
    assign lr_change = bit_event & (lrclk_s ^ lr_last);
    assign last_bit  = (bit_cnt == CNT_W'(DATA_W - 1));
    assign word      = {shreg, sdata_s};
    assign pair_done = store & chan & left_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= WAIT_ALIGN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_ALIGN: if (lr_change && !lrclk_s) state_nxt = DELAY;
            DELAY:      if (bit_event) state_nxt = SHIFT;
            SHIFT: begin
                if (bit_event) begin
                    if (last_bit) begin
                        state_nxt = lr_change ? DELAY : PAD;
                    end else if (lr_change) begin
                        state_nxt = DELAY;
                    end
                end
            end
            PAD:        if (lr_change) state_nxt = DELAY;
            default:    state_nxt = WAIT_ALIGN;
        endcase
    end

    always_comb begin
        take    = 1'b0;
        store   = 1'b0;
        abandon = 1'b0;
        case (state)
            DELAY: take = bit_event;
            SHIFT: begin
                if (bit_event) begin
                    if (last_bit) begin
                        take  = 1'b1;
                        store = 1'b1;
                    end else if (lr_change) begin
                        abandon = 1'b1;
                    end else begin
                        take = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bclk_d       <= 1'b0;
            lr_last      <= 1'b0;
            chan         <= 1'b0;
            shreg        <= '0;
            bit_cnt      <= '0;
            left_hold    <= '0;
            left_ok      <= 1'b0;
            left_data    <= '0;
            right_data   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            bclk_d <= bclk_s;
            if (bit_event) lr_last <= lrclk_s;
            if (lr_change) chan <= lrclk_s;
            if (take) begin
                shreg   <= word[DATA_W-2:0];
                bit_cnt <= (state == DELAY) ? CNT_W'(1) : bit_cnt + CNT_W'(1);
            end
            if (store && !chan) begin
                left_hold <= word;
                left_ok   <= 1'b1;
            end
            // A right word only publishes when a left word from the same frame is held.
            if (pair_done) begin
                left_data  <= left_hold;
                right_data <= word;
                left_ok    <= 1'b0;
            end
            overrun <= pair_done & sample_valid & ~sample_ready;
            if (pair_done) begin
                sample_valid <= 1'b1;
            end else if (sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= abandon;
        end
    end
`else
    logic unused_abandon;
    assign unused_abandon = abandon;
    assign frame_err      = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_mic_rx.sv
// tb/tb_i2s_mic_rx.sv - randomized half-frame stimulus against a frame-level reference model
module tb_i2s_mic_rx;

    localparam int DW   = 16;
    localparam int SYNC = 2;
`ifdef I2S_RX_FRAME_CHECK_EN
    localparam bit FE_EN = 1'b1;
`else
    localparam bit FE_EN = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        int            c;
    } pair_t;

    logic          clk, resetn, bclk, lrclk, sdata, sample_ready;
    logic [DW-1:0] left_data, right_data;
    logic          sample_valid, overrun, frame_err;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rdy_mode = 1;
    int ov_cnt   = 0;
    int fe_cnt   = 0;

    bit            m_aligned, m_seen_right, m_short, m_left_ok, m_valid, rdy_last;
    logic [DW-1:0] m_hold, m_left, m_right;
    pair_t         exp_q[$];
    int            fe_q[$];

    i2s_mic_rx #(.DATA_W(DW), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .left_data    (left_data),
        .right_data   (right_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .frame_err    (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Ready patterns: 0 random, 1 low, 2 high, 3 high only in the cycle a pair lands.
    initial begin
        sample_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       sample_ready = ($urandom_range(0, 3) == 0);
                1:       sample_ready = 1'b0;
                2:       sample_ready = 1'b1;
                default: sample_ready = (exp_q.size() > 0) && (exp_q[0].c + SYNC + 1 == cyc + 1);
            endcase
        end
    end

    // Frame-level model: a half-frame stores its word iff it began after alignment
    // and carried more than DW bit clocks; a right word pairs with an unpaired left.
    task automatic model_edge(input bit ch, input int k, input int n, input logic [DW-1:0] w);
        if (k == 0) begin
            if (m_short && FE_EN) fe_q.push_back(cyc);
            if (!m_aligned && ch == 1'b0 && m_seen_right) m_aligned = 1'b1;
            if (ch) m_seen_right = 1'b1;
            m_short = m_aligned && (n < DW);
        end
        if (m_aligned && k == DW) begin
            if (!ch) begin
                m_hold    = w;
                m_left_ok = 1'b1;
            end else if (m_left_ok) begin
                exp_q.push_back('{l: m_hold, r: w, c: cyc});
                m_left_ok = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_aligned    = 1'b0;
        m_seen_right = 1'b0;
        m_short      = 1'b0;
        m_left_ok    = 1'b0;
        m_hold       = '0;
        exp_q.delete();
        fe_q.delete();
    endtask

    task automatic do_reset();
        #10 resetn = 1'b0;
        model_reset();
        #1;
        chk("reset_left", left_data, 0);
        chk("reset_right", right_data, 0);
        chk("reset_valid", sample_valid, 0);
        #19 resetn = 1'b1;
    endtask

    task automatic drive_half(input bit ch, input int n, input logic [DW-1:0] w, input int rst_at);
        for (int k = 0; k < n; k++) begin
            lrclk = ch;
            sdata = (k >= 1 && k <= DW) ? w[DW-k] : 1'($urandom);
            #35 bclk = 1'b1;
            model_edge(ch, k, n, w);
            #35 bclk = 1'b0;
            if (k == rst_at) do_reset();
        end
    endtask

    task automatic drive_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        drive_half(1'b0, 32, l, -1);
        drive_half(1'b1, 32, r, -1);
    endtask

    function automatic int rand_len();
        return ($urandom_range(0, 4) == 0) ? 10 : int'($urandom_range(17, 32));
    endfunction

    // Per-cycle compare against the model; a stored word lands SYNC+1 clocks after its bclk rise.
    initial begin
        bit exp_ov, exp_fe;
        forever begin
            @(negedge clk);
            exp_ov = 1'b0;
            exp_fe = 1'b0;
            if (!resetn) begin
                m_valid = 1'b0;
                m_left  = '0;
                m_right = '0;
            end else begin
                if (exp_q.size() > 0 && exp_q[0].c + SYNC + 1 == cyc) begin
                    exp_ov  = m_valid && !rdy_last;
                    m_valid = 1'b1;
                    m_left  = exp_q[0].l;
                    m_right = exp_q[0].r;
                    void'(exp_q.pop_front());
                end else if (m_valid && rdy_last) begin
                    m_valid = 1'b0;
                end
                if (fe_q.size() > 0 && fe_q[0] + SYNC + 1 == cyc) begin
                    exp_fe = 1'b1;
                    void'(fe_q.pop_front());
                end
            end
            chk("sample_valid", sample_valid, m_valid);
            chk("overrun", overrun, exp_ov);
            chk("frame_err", frame_err, exp_fe);
            chk("left_data", left_data, m_left);
            chk("right_data", right_data, m_right);
            if (overrun) ov_cnt++;
            if (frame_err) fe_cnt++;
            rdy_last = sample_ready;
        end
    end

    initial begin
        logic [DW-1:0] a, b, c, d;
        int ov0, fe0;
        resetn = 1'b0;
        bclk   = 1'b0;
        lrclk  = 1'b1;
        sdata  = 1'b0;
        model_reset();
        #47;
        chk("por_left", left_data, 0);
        chk("por_valid", sample_valid, 0);
        chk("por_overrun", overrun, 0);
        #5 resetn = 1'b1;
        #100;

        // Basic pair with the consumer stalled.
        rdy_mode = 1;
        drive_half(1'b1, 32, DW'($urandom), -1);
        drive_pair(16'h1234, 16'hABCD);
        repeat (2) @(negedge clk);
        chk("basic_left", left_data, 16'h1234);
        chk("basic_right", right_data, 16'hABCD);
        chk("basic_valid", sample_valid, 1);
        rdy_mode = 2;
        repeat (3) @(negedge clk);
        chk("basic_accept", sample_valid, 0);
        #2;

        // Two pairs unconsumed: second overwrites with a single overrun.
        rdy_mode = 1;
        ov0 = ov_cnt;
        a = DW'($urandom); b = DW'($urandom); c = DW'($urandom); d = DW'($urandom);
        drive_pair(a, b);
        drive_pair(c, d);
        repeat (2) @(negedge clk);
        chk("ovr_count", ov_cnt - ov0, 1);
        chk("ovr_left", left_data, c);
        chk("ovr_right", right_data, d);
        #2;

        // Accept in the same cycle a new pair lands.
        rdy_mode = 3;
        ov0 = ov_cnt;
        a = DW'($urandom); b = DW'($urandom);
        drive_pair(a, b);
        repeat (2) @(negedge clk);
        chk("coll_overrun", ov_cnt - ov0, 0);
        chk("coll_valid", sample_valid, 1);
        chk("coll_right", right_data, b);
        rdy_mode = 2;
        repeat (3) @(negedge clk);
        #2;

        // Short right half-frame of 10 bit clocks.
        rdy_mode = 0;
        fe0 = fe_cnt;
        a = DW'($urandom); b = DW'($urandom); c = DW'($urandom);
        drive_half(1'b0, 32, a, -1);
        drive_half(1'b1, 10, DW'($urandom), -1);
        drive_pair(b, c);
        repeat (2) @(negedge clk);
        chk("short_fe_count", fe_cnt - fe0, FE_EN ? 1 : 0);
        chk("short_left", left_data, b);
        chk("short_right", right_data, c);
        #2;

        // Reset at bit 7 of a left word, then recapture.
        rdy_mode = 1;
        drive_half(1'b1, 32, DW'($urandom), -1);
        drive_half(1'b0, 32, DW'($urandom), 7);
        drive_half(1'b1, 32, DW'($urandom), -1);
        a = DW'($urandom); b = DW'($urandom);
        drive_pair(a, b);
        repeat (2) @(negedge clk);
        chk("rst_left", left_data, a);
        chk("rst_right", right_data, b);
        #2;

        // Start mid-right after reset: nothing until a full pair.
        do_reset();
        drive_half(1'b1, 7, DW'($urandom), -1);
        a = DW'($urandom); b = DW'($urandom);
        drive_half(1'b0, 32, a, -1);
        repeat (2) @(negedge clk);
        chk("mid_no_valid", sample_valid, 0);
        #2;
        drive_half(1'b1, 32, b, -1);
        repeat (2) @(negedge clk);
        chk("mid_valid", sample_valid, 1);
        chk("mid_left", left_data, a);
        #2;

        rdy_mode = 0;
        for (int i = 0; i < 12; i++) begin
            drive_half(1'b0, rand_len(), DW'($urandom), -1);
            drive_half(1'b1, rand_len(), DW'($urandom), -1);
        end

        rdy_mode = 2;
        repeat (20) @(negedge clk);
        chk("drain_pairs", exp_q.size(), 0);
        chk("drain_fe", fe_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_mic_rx.md
I2S_MIC_RX -- requirements
Module: i2s_mic_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning sample width captured per channel, MSB first.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth applied to bclk, lrclk and sdata.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic is synchronous to it.
REQ-004 SHALL have port resetn, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port bclk, input, 1, codec bit clock (3.072 MHz), asynchronous to clk.
REQ-006 SHALL have port lrclk, input, 1, codec frame clock (48 kHz); low = left, high = right.
REQ-007 SHALL have port sdata, input, 1, codec serial mic data (CDOUT).
REQ-008 SHALL have port left_data, output, DATA_W, last complete left sample.
REQ-009 SHALL have port right_data, output, DATA_W, last complete right sample.
REQ-010 SHALL have port sample_valid, output, 1, stereo pair available.
REQ-011 SHALL have port sample_ready, input, 1, consumer accepts pair.
REQ-012 SHALL have port overrun, output, 1, one-cycle pulse when a pair is overwritten.
REQ-013 SHALL have port frame_err, output, 1, one-cycle pulse on a short half-frame (I2S_RX_FRAME_CHECK_EN only; tied 0 otherwise).

Function
REQ-014 SHALL pass bclk, lrclk and sdata through identical SYNC_STAGES-deep flop chains so they stay mutually aligned.
REQ-015 SHALL define a bit event as a synchronized bclk 0->1 transition; lrclk and sdata SHALL be sampled only at bit events.
REQ-016 SHALL use standard I2S framing: the MSB is the bit event one event after the lrclk change.
REQ-017 SHALL implement states WAIT_ALIGN, DELAY, SHIFT, PAD.
REQ-018 WAIT_ALIGN: after reset, remain until a bit event sees lrclk 1->0 (start of left), then enter DELAY; partial first frames are discarded.
REQ-019 DELAY: on the next bit event capture the MSB and enter SHIFT with bit count 1.
REQ-020 SHIFT: capture one bit per bit event; when DATA_W bits are captured, store to the channel register selected by the latched lrclk and enter PAD.
REQ-021 PAD: ignore bits until an lrclk change at a bit event, then enter DELAY for the new channel.
REQ-022 An lrclk change seen in SHIFT before DATA_W bits SHALL abandon the partial word without storing it and enter DELAY.
REQ-023 On right-channel completion, left_data/right_data SHALL update and sample_valid SHALL assert on the next clk cycle (1-cycle latency from the final bit event).
REQ-024 sample_valid SHALL remain high until a cycle with sample_ready high, then deassert next cycle.
REQ-025 If a new pair completes while sample_valid is high and sample_ready is low, the data SHALL be overwritten, sample_valid SHALL stay high and overrun SHALL pulse once.
REQ-026 A completion in the same cycle as an accepted handshake SHALL count as a new pair: valid stays high, no overrun.
REQ-027 left_data SHALL not change outputs until its paired right sample completes (pair coherence, via a left holding register).

Reset
REQ-028 SHALL, on resetn low, clear all outputs to 0 and synchronizers to 0, and enter WAIT_ALIGN; reset mid-frame SHALL discard any partial word.

Configuration
REQ-029 With I2S_RX_FRAME_CHECK_EN defined, the path of REQ-022 SHALL also pulse frame_err; without it frame_err SHALL be constant 0 and that path SHALL silently discard.

Structure
REQ-030 Shared package hl_audio_pkg SHALL hold the state enum, DATA_W default and the synchronizer depth constant.
REQ-031 The synchronizer SHALL be the sub-module sync_bits (parameterized width and depth), instantiated once for all three inputs.

Verification
REQ-032 Left 0x1234, right 0xABCD, 32 bclk per half-frame -> sample_valid 1 cycle after the last right bit, left_data=0x1234, right_data=0xABCD.
REQ-033 Two pairs with sample_ready held low -> one overrun pulse, outputs show the second pair, sample_valid high throughout.
REQ-034 Start stimulus mid-right channel -> no sample_valid until the first full left+right pair.
REQ-035 Half-frame of 10 bclks -> no store; frame_err pulses with I2S_RX_FRAME_CHECK_EN defined, stays 0 without it.
REQ-036 resetn asserted at bit 7 of the left word -> outputs 0; the next full pair after release is captured correctly.
REQ-037 sample_ready high in the same cycle a new pair completes -> sample_valid stays high, overrun stays 0.
